expu_issuer: RTL and testbench

Front-end sequencer that feeds the EXPU array. It accepts a job of `len_i` scalar FP operands, one per cycle, from an upstream streamer. It packs them into `N_ROWS`-lane beats with per-lane strobes and a last-beat tag, and issues the beats over the EXPU's valid/ready input interface. Once the last beat has been accepted, it waits for the EXPU pipeline to drain and then reports job completion.

---
 rtl/expu_issuer.sv | 243 ++++++++++++++++++++++++
 tb/tb_expu_issuer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/expu_issuer.sv
// expu_issuer: packs a stream of scalar FP operands into N_ROWS-lane beats and issues them to the EXPU.
// Define EXPU_ISSUER_DOUBLE_BUFFER_EN for separate packing and output registers (ping-pong).

// Minimal stand-in for the fpnew format package, enough to size the operand width.
package fpnew_pkg;
    typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT, FP8ALT} fp_format_e;

    function automatic int unsigned fp_width(fp_format_e fmt);
        case (fmt)
            FP32:    return 32;
            FP64:    return 64;
            FP16:    return 16;
            FP16ALT: return 16;
            FP8:     return 8;
            FP8ALT:  return 8;
            default: return 16;
        endcase
    endfunction
endpackage

module expu_issuer #(
    parameter fpnew_pkg::fp_format_e FPFORMAT  = fpnew_pkg::FP16ALT,
    parameter int unsigned           N_ROWS    = 1,
    parameter int unsigned           LEN_WIDTH = 16,
    localparam int unsigned          WIDTH     = fpnew_pkg::fp_width(FPFORMAT)
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           clear_i,
    input  logic                           enable_i,
    input  logic                           start_i,
    input  logic [LEN_WIDTH-1:0]           len_i,
    input  logic                           in_valid_i,
    input  logic [WIDTH-1:0]               in_data_i,
    output logic                           in_ready_o,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [N_ROWS-1:0][WIDTH-1:0]   op_o,
    output logic [N_ROWS-1:0]              strb_o,
    output logic                           tag_o,
    input  logic                           expu_busy_i,
    output logic                           busy_o,
    output logic                           done_o
);

    localparam int unsigned             LANE_W    = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam logic [LANE_W-1:0]       LAST_LANE = LANE_W'(N_ROWS - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

    state_e                        state;
    logic [LEN_WIDTH-1:0]          remaining;
    logic [LANE_W-1:0]             lane;

    logic                          accept;
    logic                          last_op;
    logic                          close;
    logic                          hs;
    logic                          buf_free;
    logic [N_ROWS-1:0][WIDTH-1:0]  src_op;
    logic [N_ROWS-1:0]             src_strb;
    logic [N_ROWS-1:0][WIDTH-1:0]  beat_op;
    logic [N_ROWS-1:0]             beat_strb;

`ifdef EXPU_ISSUER_DOUBLE_BUFFER_EN
    logic [N_ROWS-1:0][WIDTH-1:0]  pack_op;
    logic [N_ROWS-1:0]             pack_strb;
    logic                          pack_tag;
    logic                          pack_full;

    assign src_op   = pack_op;
    assign src_strb = pack_strb;
    assign buf_free = ~pack_full;
`else
    // The output register doubles as the packing register.
    assign src_op   = op_o;
    assign src_strb = strb_o;
    assign buf_free = ~valid_o;
`endif

    assign in_ready_o = enable_i & (state == RUN) & buf_free & (remaining != '0);
    assign accept     = in_valid_i & in_ready_o;
    assign last_op    = (remaining == LEN_WIDTH'(1));
    assign close      = accept & ((lane == LAST_LANE) | last_op);
    assign hs         = enable_i & valid_o & ready_i;

    always_comb begin
        beat_op   = src_op;
        beat_strb = src_strb;
        for (int i = 0; i < N_ROWS; i++) begin
            if (lane == LANE_W'(i)) begin
                beat_op[i]   = in_data_i;
                beat_strb[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            remaining <= '0;
            lane      <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else if (clear_i) begin
            state     <= IDLE;
            remaining <= '0;
            lane      <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b0;
        end else if (enable_i) begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i) begin
                        remaining <= len_i;
                        busy_o    <= 1'b1;
                        if (len_i == '0) begin
                            state  <= DONE;
                            done_o <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (accept) begin
                        remaining <= remaining - 1'b1;
                        lane      <= close ? '0 : lane + 1'b1;
                    end
                    if (hs && tag_o) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!expu_busy_i) begin
                        state  <= DONE;
                        done_o <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef EXPU_ISSUER_DOUBLE_BUFFER_EN
    // A beat that closes while the output is stalled parks in the packing register
    // and moves to the output on the next handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o   <= 1'b0;
            op_o      <= '0;
            strb_o    <= '0;
            tag_o     <= 1'b0;
            pack_op   <= '0;
            pack_strb <= '0;
            pack_tag  <= 1'b0;
            pack_full <= 1'b0;
        end else if (clear_i) begin
            valid_o   <= 1'b0;
            op_o      <= '0;
            strb_o    <= '0;
            tag_o     <= 1'b0;
            pack_op   <= '0;
            pack_strb <= '0;
            pack_tag  <= 1'b0;
            pack_full <= 1'b0;
        end else if (enable_i) begin
            if (hs) begin
                if (pack_full) begin
                    op_o      <= pack_op;
                    strb_o    <= pack_strb;
                    tag_o     <= pack_tag;
                    pack_op   <= '0;
                    pack_strb <= '0;
                    pack_tag  <= 1'b0;
                    pack_full <= 1'b0;
                end else begin
                    valid_o <= 1'b0;
                    op_o    <= '0;
                    strb_o  <= '0;
                    tag_o   <= 1'b0;
                end
            end
            if (accept) begin
                if (close) begin
                    pack_op   <= '0;
                    pack_strb <= '0;
                    if (!valid_o || ready_i) begin
                        valid_o <= 1'b1;
                        op_o    <= beat_op;
                        strb_o  <= beat_strb;
                        tag_o   <= last_op;
                    end else begin
                        pack_op   <= beat_op;
                        pack_strb <= beat_strb;
                        pack_tag  <= last_op;
                        pack_full <= 1'b1;
                    end
                end else begin
                    pack_op   <= beat_op;
                    pack_strb <= beat_strb;
                end
            end
        end
    end
`else
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            op_o    <= '0;
            strb_o  <= '0;
            tag_o   <= 1'b0;
        end else if (clear_i) begin
            valid_o <= 1'b0;
            op_o    <= '0;
            strb_o  <= '0;
            tag_o   <= 1'b0;
        end else if (enable_i) begin
            if (hs) begin
                valid_o <= 1'b0;
                op_o    <= '0;
                strb_o  <= '0;
                tag_o   <= 1'b0;
            end else if (accept) begin
                op_o   <= beat_op;
                strb_o <= beat_strb;
                if (close) begin
                    valid_o <= 1'b1;
                    tag_o   <= last_op;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_expu_issuer.sv
// tb_expu_issuer: randomized jobs against a beat-level reference model of expu_issuer (N_ROWS=4).
// Expected beats, valid/ready levels and completion timing are derived from operand counts.

module tb_expu_issuer;

    localparam int NR = 4;
`ifdef EXPU_ISSUER_DOUBLE_BUFFER_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             enable;
    logic             start;
    logic [15:0]      len_in;
    logic             in_valid;
    logic [15:0]      in_data;
    logic             in_ready;
    logic             valid;
    logic             ready;
    logic [3:0][15:0] op;
    logic [3:0]       strb;
    logic             tag;
    logic             expu_busy;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    expu_issuer #(.N_ROWS(NR), .LEN_WIDTH(16)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .clear_i     (clear),
        .enable_i    (enable),
        .start_i     (start),
        .len_i       (len_in),
        .in_valid_i  (in_valid),
        .in_data_i   (in_data),
        .in_ready_o  (in_ready),
        .valid_o     (valid),
        .ready_i     (ready),
        .op_o        (op),
        .strb_o      (strb),
        .tag_o       (tag),
        .expu_busy_i (expu_busy),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", name, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string pfx);
        checkOutput({pfx, "_valid"},    64'(valid),    64'(0));
        checkOutput({pfx, "_op"},       64'(op),       64'(0));
        checkOutput({pfx, "_strb"},     64'(strb),     64'(0));
        checkOutput({pfx, "_tag"},      64'(tag),      64'(0));
        checkOutput({pfx, "_in_ready"}, 64'(in_ready), 64'(0));
        checkOutput({pfx, "_busy"},     64'(busy),     64'(0));
        checkOutput({pfx, "_done"},     64'(done),     64'(0));
    endtask

    // Starts a job and feeds n operands with the output stalled, then stops feeding.
    task automatic feedPartial(input int len, input int n);
        @(negedge clk);
        start = 1; len_in = 16'(len); enable = 1; ready = 0; in_valid = 0; clear = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            start = 0; in_valid = 1; in_data = 16'($urandom);
        end
        @(negedge clk);
        start = 0; in_valid = 0;
    endtask

    // Runs one complete job. vmode/rmode/emode: 0 = always asserted, 1 = random;
    // rmode 2 holds ready low for 5 cycles on the first beat. bhold: cycles expu_busy
    // stays high after the final handshake.
    task automatic applyStimulus(input int len, input int vmode, input int rmode, input int emode, input int bhold);
        logic [15:0] ops[$];
        logic [63:0] exp_op[$];
        logic [3:0]  exp_strb[$];
        logic        exp_tag[$];
        logic [63:0] beat;
        logic [3:0]  s;
        logic [63:0] prev_op = '0;
        logic [3:0]  prev_strb = '0;
        logic        prev_tag = 0;
        logic        prev_valid = 0;
        logic        prev_hs = 0;
        logic        hs;
        logic        exp_rdy;
        int accepted = 0, closed = 0, shaken = 0, cyc = 0, stall_cnt = 0;
        int final_cyc = -1, since = 0, nbeats, outstanding;
        bit finished = 0;

        nbeats = (len + NR - 1) / NR;
        for (int i = 0; i < len; i++) ops.push_back(16'($urandom));
        for (int b = 0; b < nbeats; b++) begin
            beat = '0;
            s    = '0;
            for (int l = 0; l < NR && b * NR + l < len; l++) begin
                beat = beat | (64'(ops[b * NR + l]) << (16 * l));
                s[l] = 1'b1;
            end
            exp_op.push_back(beat);
            exp_strb.push_back(s);
            exp_tag.push_back((b + 1) == nbeats);
        end

        @(negedge clk);
        start = 1; len_in = 16'(len); in_valid = 0; ready = 0; enable = 1; clear = 0;
        #1;
        checkOutput("idle_busy", 64'(busy), 64'(0));

        while (!finished && cyc < 600) begin
            @(negedge clk);
            if (final_cyc >= 0) since = cyc - final_cyc;
            enable   = (cyc == 0 || final_cyc >= 0 || emode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            start    = (cyc != 0 && final_cyc < 0 && $urandom_range(0, 5) == 0);
            len_in   = 16'($urandom);
            in_valid = (vmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            in_data  = (accepted < len) ? ops[accepted] : 16'($urandom);
            if (rmode == 2 && shaken == 0 && valid && stall_cnt < 5) begin
                ready = 0;
                stall_cnt++;
            end else begin
                ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            expu_busy = (final_cyc >= 0) ? (since <= bhold) : 1'($urandom_range(0, 1));
            #1;

            outstanding = closed - shaken;
            exp_rdy = enable && (accepted < len) && (outstanding < DEPTH);
            checkOutput("valid_level", 64'(valid), 64'(outstanding > 0));
            checkOutput("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (cyc == 0) checkOutput("first_in_ready", 64'(in_ready), 64'(1));
            if (prev_valid && !prev_hs) begin
                checkOutput("hold_op", 64'(op), prev_op);
                checkOutput("hold_strb", 64'(strb), 64'(prev_strb));
                checkOutput("hold_tag", 64'(tag), 64'(prev_tag));
            end
            if (final_cyc >= 0) begin
                checkOutput("done_timing", 64'(done), 64'(since == bhold + 2));
                checkOutput("busy_tail", 64'(busy), 64'(since <= bhold + 2));
                if (since == bhold + 3) finished = 1;
            end else begin
                checkOutput("done_early", 64'(done), 64'(0));
                checkOutput("busy_run", 64'(busy), 64'(1));
            end

            hs = enable && valid && ready;
            if (hs && !finished) begin
                if (exp_op.size() == 0) begin
                    checkOutput("extra_beat", 64'(1), 64'(0));
                end else begin
                    checkOutput("beat_op", 64'(op), exp_op.pop_front());
                    checkOutput("beat_strb", 64'(strb), 64'(exp_strb.pop_front()));
                    checkOutput("beat_tag", 64'(tag), 64'(exp_tag.pop_front()));
                end
                shaken++;
                if (shaken == nbeats) final_cyc = cyc;
            end
            if (!finished && enable && in_valid && in_ready) begin
                accepted++;
                closed = (accepted == len) ? nbeats : accepted / NR;
            end
            prev_op    = 64'(op);
            prev_strb  = strb;
            prev_tag   = tag;
            prev_valid = valid;
            prev_hs    = hs;
            if (!finished) cyc++;
        end
        checkOutput("job_complete", 64'(finished), 64'(1));
        in_valid = 0; start = 0; ready = 0; expu_busy = 0; enable = 1;
    endtask

    initial begin
        clk = 0; rst_n = 0; clear = 0; enable = 1; start = 0; len_in = '0;
        in_valid = 0; in_data = '0; ready = 0; expu_busy = 0;
        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1;

        $display("[TB] len=8 continuous, always ready");
        applyStimulus(8, 0, 0, 0, 3);
        $display("[TB] len=6 partial final beat");
        applyStimulus(6, 0, 0, 0, 0);
        $display("[TB] first beat stalled 5 cycles");
        applyStimulus(7, 0, 2, 0, 1);

        $display("[TB] zero-length job");
        @(negedge clk);
        start = 1; len_in = '0;
        @(negedge clk);
        start = 0;
        #1;
        checkOutput("len0_done", 64'(done), 64'(1));
        checkOutput("len0_valid", 64'(valid), 64'(0));
        checkOutput("len0_busy", 64'(busy), 64'(1));
        @(negedge clk);
        #1;
        checkOutput("len0_done_end", 64'(done), 64'(0));
        checkOutput("len0_idle", 64'(busy), 64'(0));

        $display("[TB] clear after 3 operands");
        feedPartial(10, 3);
        clear = 1;
        @(negedge clk);
        clear = 0;
        #1;
        checkResetValues("clear");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            checkOutput("clear_no_done", 64'(done), 64'(0));
        end
        applyStimulus(4, 0, 0, 0, 0);

        $display("[TB] async reset with a beat pending");
        feedPartial(8, 4);
        #1;
        checkOutput("pre_reset_valid", 64'(valid), 64'(1));
        #1;
        rst_n = 0;
        #1;
        checkResetValues("async_reset");
        @(negedge clk);
        rst_n = 1;
        applyStimulus(5, 0, 0, 0, 0);

        $display("[TB] long drain with enable gaps");
        applyStimulus(9, 1, 1, 1, 10);

        $display("[TB] random jobs");
        for (int j = 0; j < 5; j++) begin
            applyStimulus($urandom_range(1, 13), 1, 1, 1, $urandom_range(0, 4));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
